// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream side (in_*) and downstream side (out_*).
//   in_valid/in_ready/in_ctrl/in_data     : beat offered by the previous stage
//   out_valid/out_ready/out_ctrl/out_data : head entry offered to the next stage
// master : environment view (drives in_* and out_ready)
// slave  : stage view (drives in_ready and out_*)
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and optional 2-entry skid buffer.
// Data is retained on bubbles; control is zeroed whenever the entry is invalid.
//   clk, reset : clock, synchronous active-high reset
//   flush      : synchronous kill of every held entry (out_data keeps its value)
//   bus        : pipe_stage_reg_if.slave (in_* from upstream, out_* to downstream)
//   occupancy  : number of held entries (0..2)
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_reg_if.slave       bus,
    output logic [1:0]            occupancy
);

    logic              head_valid_q, head_valid_d;
    logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [1:0]        occupancy_q,  occupancy_d;
    logic              in_ready_c;
    logic              xfer_in_c;
    logic              xfer_out_c;

    // Handshake: registered ready with the skid buffer, pass-through ready without it.
    always_comb begin
        in_ready_c = (SKID != 0) ? in_ready_q : (~head_valid_q | bus.out_ready);
        xfer_in_c  = bus.in_valid & in_ready_c;
        xfer_out_c = head_valid_q & bus.out_ready;
    end

    // Next-state for head/skid entries.
    always_comb begin
        head_valid_d = head_valid_q;
        head_ctrl_d  = head_ctrl_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Kill everything, including a beat accepted this cycle; payload is left as-is.
            head_valid_d = 1'b0;
            head_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (SKID == 0) begin
            if (xfer_in_c) begin
                head_valid_d = 1'b1;
                head_ctrl_d  = bus.in_ctrl;
                head_data_d  = bus.in_data;
            end else if (xfer_out_c) begin
                head_valid_d = 1'b0;
                head_ctrl_d  = '0;
            end
        end else begin
            case ({head_valid_q, skid_valid_q})
                2'b00: begin
                    if (xfer_in_c) begin
                        head_valid_d = 1'b1;
                        head_ctrl_d  = bus.in_ctrl;
                        head_data_d  = bus.in_data;
                    end
                end
                2'b10: begin
                    if (xfer_in_c && xfer_out_c) begin
                        head_ctrl_d = bus.in_ctrl;
                        head_data_d = bus.in_data;
                    end else if (xfer_in_c) begin
                        // Downstream stalled: the younger beat parks in the skid entry.
                        skid_valid_d = 1'b1;
                        skid_ctrl_d  = bus.in_ctrl;
                        skid_data_d  = bus.in_data;
                    end else if (xfer_out_c) begin
                        head_valid_d = 1'b0;
                        head_ctrl_d  = '0;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only the drain case moves anything.
                    if (xfer_out_c) begin
                        head_ctrl_d  = skid_ctrl_q;
                        head_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = '0;
                    end
                end
                default: begin
                    // Skid without head is unreachable; drop it to recover.
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = '0;
                end
            endcase
        end

        in_ready_d  = ~(head_valid_d & skid_valid_d);
        occupancy_d = 2'(head_valid_d) + 2'(skid_valid_d);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_q <= 1'b0;
            head_ctrl_q  <= '0;
            head_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            occupancy_q  <= 2'd0;
        end else begin
            head_valid_q <= head_valid_d;
            head_ctrl_q  <= head_ctrl_d;
            head_data_q  <= head_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = head_valid_q;
    assign bus.out_ctrl  = head_ctrl_q;
    assign bus.out_data  = head_data_q;
    assign occupancy     = occupancy_q;

endmodule
